// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Multiply is shift-add over a 2*DATA_WIDTH product register.
// Divide is restoring shift-subtract sharing the same register.
// Magnitudes are processed unsigned and the sign is fixed up in FIN.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  ALL_ONES = {W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Architectural state.
    state_t          state_q,   state_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [2:0]      op_q,      op_d;
    logic [W-1:0]    opnd_q,    opnd_d;
    logic [2*W-1:0]  prod_q,    prod_d;
    logic            neg_q,     neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            done_q,    done_d;
    logic [W-1:0]    result_q,  result_d;

    // Operand decode signals.
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic            div_zero;
    logic            div_ovf;

    // Iteration datapath signals.
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    logic [W:0]      div_trial;
    logic [2*W-1:0]  div_next;

    // Result fix-up signals.
    logic [2*W-1:0]  full_prod;
    logic [W-1:0]    quot;
    logic [W-1:0]    rem;
    logic [W-1:0]    final_res;

    // Classify the incoming request: signedness, magnitudes and special cases.
    always_comb begin
        is_div   = funct3[2];
        a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed = is_div ? ~funct3[0] : ~funct3[1];
        a_neg    = a_signed & op_a[W-1];
        b_neg    = b_signed & op_b[W-1];
        a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
        b_mag    = b_neg ? (~op_b + 1'b1) : op_b;
        div_zero = is_div & (op_b == '0);
        div_ovf  = is_div & ~funct3[0] & (op_a == MOST_NEG) & (op_b == ALL_ONES);
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum = {1'b0, prod_q[2*W-1:W]} + {1'b0, opnd_q};
        if (prod_q[0]) begin
            mul_next = {mul_sum, prod_q[W-1:1]};
        end else begin
            mul_next = {1'b0, prod_q[2*W-1:1]};
        end

        div_trial = prod_q[2*W-1:W-1] - {1'b0, opnd_q};
        if (!div_trial[W]) begin
            div_next = {div_trial[W-1:0], prod_q[W-2:0], 1'b1};
        end else begin
            div_next = {prod_q[2*W-2:0], 1'b0};
        end
    end

    // Sign correction and selection of the architectural result.
    always_comb begin
        full_prod = neg_q ? (~prod_q + 1'b1) : prod_q;
        quot      = neg_q ? (~prod_q[W-1:0] + 1'b1) : prod_q[W-1:0];
        rem       = rem_neg_q ? (~prod_q[2*W-1:W] + 1'b1) : prod_q[2*W-1:W];
        if (op_q[2]) begin
            final_res = op_q[1] ? rem : quot;
        end else if (op_q[1:0] == 2'b00) begin
            final_res = full_prod[W-1:0];
        end else begin
            final_res = full_prod[2*W-1:W];
        end
    end

    // Next-state logic for the IDLE/CALC/FIN sequencer and its datapath registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        prod_d    = prod_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        done_d    = 1'b0;
        result_d  = result_q;

        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d  = funct3;
                    cnt_d = '0;
                    if (div_zero) begin
                        // Divide by zero: quotient all ones, remainder is the dividend.
                        opnd_d    = '0;
                        neg_d     = 1'b0;
                        rem_neg_d = 1'b0;
                        prod_d    = funct3[1] ? {op_a, {W{1'b0}}} : {{W{1'b0}}, ALL_ONES};
                        state_d   = FIN;
                    end else if (div_ovf) begin
                        // Signed overflow: quotient is the dividend, remainder zero.
                        opnd_d    = '0;
                        neg_d     = 1'b0;
                        rem_neg_d = 1'b0;
                        prod_d    = funct3[1] ? '0 : {{W{1'b0}}, op_a};
                        state_d   = FIN;
                    end else if (is_div) begin
                        opnd_d    = b_mag;
                        prod_d    = {{W{1'b0}}, a_mag};
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                        state_d   = CALC;
                    end else begin
                        opnd_d    = a_mag;
                        prod_d    = {{W{1'b0}}, b_mag};
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = 1'b0;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    prod_d = op_q[2] ? div_next : mul_next;
                    if (cnt_q == CNT_LAST) begin
                        state_d = FIN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!flush) begin
                    result_d = final_res;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset that discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            prod_q    <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            prod_q    <= prod_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for the iterative RV32M multiply/divide unit.
// Stimulus pushes expected results from an arithmetic reference model;
// an independent monitor pops and compares on every done pulse.
module tb_muldiv_unit;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Reference RV32M semantics written with plain wide arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] up;
        longint      sp;
        int          sa;
        int          sb;
        logic [31:0] r;
        sa = a;
        sb = b;
        r  = '0;
        case (f)
            3'b000: begin up = {32'b0, a} * {32'b0, b}; r = up[31:0]; end
            3'b001: begin sp = longint'(sa) * longint'(sb); up = sp; r = up[63:32]; end
            3'b010: begin sp = longint'(sa) * longint'({32'b0, b}); up = sp; r = up[63:32]; end
            3'b011: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
            3'b100: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = 32'(sa / sb);
            end
            3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = 32'(sa % sb);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit isSpecial(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one accepted operation (called at a negedge while IDLE) and time its completion.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int cycles;
        int busy_cycles;
        int exp_lat;
        int exp_busy;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        exp_q.push_back(refModel(f, a, b));
        exp_lat  = isSpecial(f, a, b) ? 2 : W + 2;
        exp_busy = isSpecial(f, a, b) ? 1 : W + 1;
        @(negedge clk);
        start       = 1'b0;
        cycles      = 1;
        busy_cycles = 0;
        while (!done && cycles < 200) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout: no done for funct3=%0d a=%h b=%h", f, a, b);
        end else begin
            checkOutput("latency", 32'(cycles), 32'(exp_lat));
            checkOutput("busy_cycles", 32'(busy_cycles), 32'(exp_busy));
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got result %h expected no done", result);
            end else begin
                checkOutput("result", result, exp_q.pop_front());
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prev_res;
        int          r;

        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD);
        applyStimulus(3'b001, 32'h8000_0000, 32'h8000_0000);
        applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(3'b101, 32'd100, 32'd7);
        applyStimulus(3'b111, 32'd100, 32'd7);
        applyStimulus(3'b101, 32'd5, 32'd0);
        applyStimulus(3'b110, 32'd5, 32'd0);
        applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);

        // Randomized operations with biased corner cases.
        for (int i = 0; i < 30; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0) b = 32'd0;
            else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (r <= 4) b = 32'($urandom_range(1, 1000));
            if (r == 5) a = 32'($urandom_range(0, 100));
            applyStimulus(f, a, b);
        end

        // Flush together with start in IDLE drops the request.
        applyStimulus(3'b011, 32'hFFFF_FFFF, 32'h0000_0003);
        prev_res = refModel(3'b011, 32'hFFFF_FFFF, 32'h0000_0003);
        funct3 = 3'b000;
        op_a   = 32'd9;
        op_b   = 32'd9;
        start  = 1'b1;
        flush  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        checkOutput("flush_start_busy", {31'b0, busy}, 32'd0);

        // Flush in CALC at counter 10 aborts silently.
        funct3 = 3'b001;
        op_a   = $urandom;
        op_b   = $urandom;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("calc_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", {31'b0, busy}, 32'd0);
        checkOutput("flush_done", {31'b0, done}, 32'd0);
        checkOutput("flush_result", result, prev_res);
        applyStimulus(3'b100, 32'd1000, 32'hFFFF_FFF6);

        // Start during FIN is ignored; one cycle later it is accepted.
        funct3 = 3'b000;
        op_a   = 32'd12345;
        op_b   = 32'd678;
        start  = 1'b1;
        exp_q.push_back(refModel(3'b000, 32'd12345, 32'd678));
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        checkOutput("fin_busy", {31'b0, busy}, 32'd1);
        checkOutput("fin_done", {31'b0, done}, 32'd0);
        funct3 = 3'b101;
        op_a   = 32'd1000;
        op_b   = 32'd3;
        start  = 1'b1;
        @(negedge clk);
        checkOutput("done_after_fin", {31'b0, done}, 32'd1);
        applyStimulus(3'b111, 32'd1000, 32'd7);

        // Reset in the middle of CALC clears everything with no done pulse.
        funct3 = 3'b101;
        op_a   = $urandom;
        op_b   = 32'd3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD);

        repeat (3) @(negedge clk);
        checkOutput("outstanding", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
